multi_pattern_comparator: RTL and testbench

//  Streaming matcher that detects up to NUM_PATTERNS byte patterns at any byte alignment in the sniffer datapath.

---
 rtl/multi_pattern_comparator.sv | 136 +++++++++++++
 tb/tb_multi_pattern_comparator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multi_pattern_comparator.sv
// multi_pattern_comparator
//   Streaming byte-pattern matcher. Each pattern is compared at every byte alignment
//   of the window {history, data_in}, so it also catches patterns that straddle word
//   boundaries. Data is forwarded with one beat of latency, aligned with the match flags.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear           sync clear of history, sticky flag and counter; kills hits this cycle
//   data_valid      data_in carries a valid beat
//   data_in         stream word, MSB byte = lane 0 = first on wire
//   pattern_in      pattern p at [p*8*PATTERN_BYTES +: 8*PATTERN_BYTES], MSB byte first
//   pattern_en      per-pattern enable
//   data_out        data_in registered on valid beats (holds otherwise)
//   data_out_valid  registered data_valid
//   match_pulse     at least one hit in the beat now on data_out
//   match_id        winning pattern (lowest index), 0 when no pulse
//   match_offset    lane of the final byte of the winning hit, 0 when no pulse
//   match           sticky hit flag
//   match_count     saturating count of beats with at least one hit
module multi_pattern_comparator #(
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned PATTERN_BYTES = 4,
  parameter int unsigned NUM_PATTERNS  = 4,
  parameter int unsigned COUNT_W       = 16,
  localparam int unsigned IdW  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int unsigned OffW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear,
  input  logic                                    data_valid,
  input  logic [8*DATA_BYTES-1:0]                 data_in,
  input  logic [8*PATTERN_BYTES*NUM_PATTERNS-1:0] pattern_in,
  input  logic [NUM_PATTERNS-1:0]                 pattern_en,
  output logic [8*DATA_BYTES-1:0]                 data_out,
  output logic                                    data_out_valid,
  output logic                                    match_pulse,
  output logic [IdW-1:0]                          match_id,
  output logic [OffW-1:0]                         match_offset,
  output logic                                    match,
  output logic [COUNT_W-1:0]                      match_count
);

  localparam int unsigned HistBytes = PATTERN_BYTES - 1;
  localparam int unsigned WinBytes  = HistBytes + DATA_BYTES;
  localparam int unsigned SeenW     = $clog2(PATTERN_BYTES);

  logic [8*HistBytes-1:0] hist;
  logic [SeenW-1:0]       bytes_seen;
  logic [SeenW-1:0]       bytes_seen_nxt;
  logic [8*WinBytes-1:0]  window;
  logic [DATA_BYTES-1:0]  eligible;
  logic                   hit_any;
  logic [IdW-1:0]         hit_id;
  logic [OffW-1:0]        hit_off;
  logic [31:0]            seen_sum;

  assign window = {hist, data_in};

  // A lane is eligible only if every history byte it uses arrived since rst/clear,
  // so zeroed or stale history can never produce a hit.
  always_comb begin
    eligible = '0;
    for (int unsigned j = 0; j < DATA_BYTES; j++) begin
      if (j >= HistBytes) begin
        eligible[j] = 1'b1;
      end else begin
        eligible[j] = (HistBytes - j) <= 32'(bytes_seen);
      end
    end
  end

  always_comb begin
    seen_sum       = 32'(bytes_seen) + DATA_BYTES;
    bytes_seen_nxt = (seen_sum >= HistBytes) ? SeenW'(HistBytes) : SeenW'(seen_sum);
  end

  // First hit found wins: lowest pattern index, then lowest lane.
  always_comb begin
    hit_any = 1'b0;
    hit_id  = '0;
    hit_off = '0;
    for (int unsigned p = 0; p < NUM_PATTERNS; p++) begin
      for (int unsigned j = 0; j < DATA_BYTES; j++) begin
        // Candidate ending at lane j occupies window bits starting at (DATA_BYTES-1-j) bytes.
        if (!hit_any && data_valid && !clear && pattern_en[p] && eligible[j] &&
            (window[(DATA_BYTES-1-j)*8 +: 8*PATTERN_BYTES] ==
             pattern_in[p*8*PATTERN_BYTES +: 8*PATTERN_BYTES])) begin
          hit_any = 1'b1;
          hit_id  = IdW'(p);
          hit_off = OffW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist           <= '0;
      bytes_seen     <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      match_pulse    <= 1'b0;
      match_id       <= '0;
      match_offset   <= '0;
      match          <= 1'b0;
      match_count    <= '0;
    end else begin
      data_out_valid <= data_valid;
      if (data_valid) begin
        data_out <= data_in;
      end
      match_pulse  <= hit_any;
      match_id     <= hit_id;
      match_offset <= hit_off;
      if (clear) begin
        // The beat arriving with clear is forwarded but never enters history.
        hist        <= '0;
        bytes_seen  <= '0;
        match       <= 1'b0;
        match_count <= '0;
      end else begin
        if (data_valid) begin
          hist       <= window[8*HistBytes-1:0];
          bytes_seen <= bytes_seen_nxt;
        end
        if (hit_any) begin
          match <= 1'b1;
          if (match_count != {COUNT_W{1'b1}}) begin
            match_count <= match_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_pattern_comparator.sv
// Directed bench for multi_pattern_comparator (4-byte words, 4-byte patterns, 2 patterns).
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_multi_pattern_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_valid;
  logic [31:0] data_in;
  logic [63:0] pattern_in;
  logic [1:0]  pattern_en;

  logic [31:0] data_out;
  logic        data_out_valid;
  logic        match_pulse;
  logic        match_id;
  logic [1:0]  match_offset;
  logic        match;
  logic [15:0] match_count;

  logic [31:0] s_data_out;
  logic        s_data_out_valid;
  logic        s_match_pulse;
  logic        s_match_id;
  logic [1:0]  s_match_offset;
  logic        s_match;
  logic [1:0]  s_match_count;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] P0 = 32'hC0A80101;
  localparam logic [31:0] P1 = 32'h0A000001;

  always #5 clk = ~clk;

  multi_pattern_comparator #(
    .DATA_BYTES(4), .PATTERN_BYTES(4), .NUM_PATTERNS(2), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .pattern_in(pattern_in), .pattern_en(pattern_en), .data_out(data_out),
    .data_out_valid(data_out_valid), .match_pulse(match_pulse), .match_id(match_id),
    .match_offset(match_offset), .match(match), .match_count(match_count)
  );

  multi_pattern_comparator #(
    .DATA_BYTES(4), .PATTERN_BYTES(4), .NUM_PATTERNS(2), .COUNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .pattern_in(pattern_in), .pattern_en(pattern_en), .data_out(s_data_out),
    .data_out_valid(s_data_out_valid), .match_pulse(s_match_pulse), .match_id(s_match_id),
    .match_offset(s_match_offset), .match(s_match), .match_count(s_match_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge; outputs settle 1 ns after the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_hit(input string tag, input logic p, input logic [1:0] id,
                           input logic [1:0] off);
    check({tag, " pulse"}, 64'(match_pulse), 64'(p));
    check({tag, " id"}, 64'(match_id), 64'(id));
    check({tag, " offset"}, 64'(match_offset), 64'(off));
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    pattern_in = {P1, P0};
    pattern_en = 2'b11;
    repeat (2) @(negedge clk);
    check("por data_out", 64'(data_out), 64'h0);
    check("por count", 64'(match_count), 64'h0);
    rst = 1'b0;

    // Aligned hit on the very first beat: only lane 3 is eligible, and it matches.
    step(1'b1, P0, 1'b0);
    check_hit("aligned", 1'b1, 2'd0, 2'd3);
    check("aligned match", 64'(match), 64'h1);
    check("aligned count", 64'(match_count), 64'h1);
    check("aligned data_out", 64'(data_out), 64'hC0A80101);
    check("aligned dv", 64'(data_out_valid), 64'h1);

    // Idle cycle: data_out holds, pulse drops, sticky flag stays.
    step(1'b0, 32'hDEADBEEF, 1'b0);
    check_hit("idle", 1'b0, 2'd0, 2'd0);
    check("idle dv", 64'(data_out_valid), 64'h0);
    check("idle data_out", 64'(data_out), 64'hC0A80101);
    check("idle match", 64'(match), 64'h1);

    // Mid-stream reset clears everything without waiting for a clock edge.
    step(1'b1, 32'h12345678, 1'b0);
    rst = 1'b1;
    #1;
    check("rst data_out", 64'(data_out), 64'h0);
    check("rst dv", 64'(data_out_valid), 64'h0);
    check("rst pulse", 64'(match_pulse), 64'h0);
    check("rst match", 64'(match), 64'h0);
    check("rst count", 64'(match_count), 64'h0);
    @(negedge clk);
    data_valid = 1'b0;
    rst        = 1'b0;

    // Pattern split across two beats, ending at lane 2.
    step(1'b1, 32'h000000C0, 1'b0);
    check_hit("split b1", 1'b0, 2'd0, 2'd0);
    step(1'b1, 32'hA8010100, 1'b0);
    check_hit("split b2", 1'b1, 2'd0, 2'd2);
    check("split count", 64'(match_count), 64'h1);
    check("split match", 64'(match), 64'h1);

    // hist becomes C0A801; the next beat would hit at lane 0 but arrives with clear.
    step(1'b1, 32'hAAC0A801, 1'b0);
    check_hit("pre-clear", 1'b0, 2'd0, 2'd0);
    step(1'b1, 32'h01223344, 1'b1);
    check_hit("clear beat", 1'b0, 2'd0, 2'd0);
    check("clear data_out", 64'(data_out), 64'h01223344);
    check("clear match", 64'(match), 64'h0);
    check("clear count", 64'(match_count), 64'h0);
    // History is empty after clear, so 01 at lane 0 cannot complete C0A80101.
    step(1'b1, 32'h01000000, 1'b0);
    check_hit("post-clear", 1'b0, 2'd0, 2'd0);

    // Eligibility: an all-zero pattern must not match against zeroed history.
    pattern_in = {32'h00000000, P0};
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h00000000, 1'b0);
    check_hit("elig first", 1'b1, 2'd1, 2'd3);
    step(1'b1, 32'h00000000, 1'b0);
    check_hit("elig full", 1'b1, 2'd1, 2'd0);
    // Four overlapping hits in that beat count once.
    check("elig count", 64'(match_count), 64'h2);

    // Priority between patterns, and pattern_en taking effect immediately.
    pattern_in = {P0, P0};
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, P0, 1'b0);
    check_hit("prio both", 1'b1, 2'd0, 2'd3);
    pattern_en = 2'b10;
    step(1'b1, P0, 1'b0);
    check_hit("prio en10", 1'b1, 2'd1, 2'd3);
    pattern_en = 2'b00;
    step(1'b1, P0, 1'b0);
    check_hit("prio en00", 1'b0, 2'd0, 2'd0);

    // Saturation: five hit beats after clear; the 2-bit counter stops at 3.
    pattern_en = 2'b11;
    pattern_in = {P1, P0};
    step(1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, P0, 1'b0);
      check("sat count", 64'(s_match_count), 64'((k > 3) ? 3 : k));
    end
    check("wide count", 64'(match_count), 64'h5);
    check("sat match", 64'(s_match), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
